id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have in_valid  input  1 / in_pc  input  16 / in_rs1_addr, in_rs2_addr, in_rd_addr  input  2 each / in_rs1_data, in_rs2_data, in_imm  input  16 each / in_use_imm  input  1 (B = imm) / in_reg_write  input  1 / in_alu_ctrl  input  6 (decode bundle).
REQ-004 SHALL have stall  input  1 (hold contents) / flush  input  1 (insert bubble).
REQ-005 SHALL have ex_reg_write  input  1 / ex_rd_addr  input  2 / ex_result  input  16 (instruction now in EX); wb_reg_write  input  1 / wb_rd_addr  input  2 / wb_result  input  16 (instruction now in WB).
REQ-006 SHALL have out_valid  output  1 / out_pc  output  16 / alu_a, alu_b  output  16 / alu_ctrl  output  6 / out_rd_addr  output  2 / out_reg_write  output  1 (all registered).
REQ-007 SHALL have hazard_stall  output  1 (combinational; request to upstream to hold decode).

Function
REQ-008 SHALL capture the decode bundle on each clk edge where reset=0, flush=0, stall=0, hazard_stall=0; outputs valid one cycle after capture.
REQ-009 SHALL select rs1 operand: ex_result if ex_reg_write and ex_rd_addr==in_rs1_addr; else wb_result if wb_reg_write and wb_rd_addr==in_rs1_addr; else in_rs1_data. Same for rs2.
REQ-010 SHALL load alu_a = rs1 operand; alu_b = in_imm when in_use_imm=1, else rs2 operand.
REQ-011 SHALL, on flush=1, load a bubble: out_valid=0, out_reg_write=0, alu_ctrl=6'd0, data outputs 16'h0000, out_rd_addr=0.
REQ-012 SHALL, on stall=1 (flush=0), hold all outputs, except: if wb_reg_write and wb_rd_addr matches the held source register, the held alu_a (or alu_b when register-sourced) SHALL update to wb_result.
REQ-013 SHALL track held source addresses and the use_imm flag internally to support REQ-012.
REQ-014 SHALL give priority reset > flush > stall > hazard_stall > capture.
REQ-015 SHALL treat in_valid=0 capture as a bubble (REQ-011 values).
REQ-016 SHALL never assert out_reg_write while out_valid=0.
REQ-017 SHALL pass in_alu_ctrl unmodified (codes 0-13, 28, 29); no decode of ALU codes.

Reset
REQ-018 SHALL, on clk edge with reset=1, set out_valid=0, out_reg_write=0, out_pc, alu_a, alu_b=16'h0000, alu_ctrl=6'd0, out_rd_addr=0, held source state cleared.
REQ-019 SHALL discard any in-progress stall/hold on reset; first capture possible on the edge after reset deasserts.

Configuration
REQ-020 SHALL, with ID_EX_FORWARD_EN defined, implement REQ-009/REQ-012 and tie hazard_stall=0.
REQ-021 SHALL, without ID_EX_FORWARD_EN, use in_rs*_data only, assert hazard_stall when in_valid and a register-sourced operand matches an ex or wb writer's rd, and load a bubble (REQ-011) that cycle; REQ-012 update disabled.

Structure
REQ-022 SHALL take DATA_W=16, REG_ADDR_W=2, ALU_CTRL_W=6 and ALU code constants from shared package cpu_pkg (shared with the ALU).
REQ-023 SHALL place operand selection (REQ-009) in one sub-module fwd_mux, instantiated twice.

Verification
REQ-024 No hazard: rs1=1 data 16'h0005, rs2=2 data 16'h0003, ctrl 6'd0 -> next cycle alu_a=5, alu_b=3, alu_ctrl=0, out_valid=1.
REQ-025 EX+WB both write r1 (ex_result=16'h00AA, wb_result=16'h00BB), in_rs1_addr=1 -> alu_a=16'h00AA (EX priority); only WB -> 16'h00BB.
REQ-026 Capture, then stall 3 cycles with wb writing r2=16'h1234 on cycle 2 -> alu_b becomes 16'h1234, other outputs unchanged, out_valid=1 throughout.
REQ-027 stall=1 and flush=1 same edge -> bubble (out_valid=0, alu_ctrl=0); reset=1 with flush=0, stall=1 -> all outputs zero.
REQ-028 in_use_imm=1, in_imm=16'h00FF, rs2 forwarded match -> alu_b=16'h00FF; without ID_EX_FORWARD_EN, rs1 match on ex writer -> hazard_stall=1 and bubble loaded.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- widths, ALU codes and the ID/EX bundle type, shared with the ALU.
// Also holds rd_hit(), the writer/source match used for forwarding and hazards.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 2;
  localparam int ALU_CTRL_W = 6;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 6'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 6'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 6'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 6'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 6'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 6'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 6'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 6'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 6'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 6'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = 6'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULH  = 6'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSA = 6'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 6'd13;
  localparam logic [ALU_CTRL_W-1:0] ALU_EQ    = 6'd28;
  localparam logic [ALU_CTRL_W-1:0] ALU_NE    = 6'd29;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
  } id_ex_t;

  function automatic logic rd_hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] src
  );
    return we && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux -- one source operand: EX result, else WB result, else register data.
// Ports: src_addr/reg_data in, ex_*/wb_* writer info in, operand out.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     operand
);

  // EX is the younger writer, so it wins over WB.
  always_comb begin
    operand = reg_data;
    if (rd_hit(ex_reg_write, ex_rd_addr, src_addr))
      operand = ex_result;
    else if (rd_hit(wb_reg_write, wb_rd_addr, src_addr))
      operand = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding or hazard stall.
// Ports: decode bundle in_*, stall/flush, ex_*/wb_* writers; registered ALU
// operands out, hazard_stall out. Macro ID_EX_FORWARD_EN selects forwarding;
// without it, any register-operand match on EX/WB raises hazard_stall.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0]     in_rs1_data,
  input  logic [DATA_W-1:0]     in_rs2_data,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_use_imm,
  input  logic                  in_reg_write,
  input  logic [ALU_CTRL_W-1:0] in_alu_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_result,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_pc,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  hazard_stall
);

  id_ex_t q;
  id_ex_t d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  fwd_mux u_fwd_a (
    .src_addr     (in_rs1_addr),
    .reg_data     (in_rs1_data),
    .ex_reg_write (ex_reg_write),
    .ex_rd_addr   (ex_rd_addr),
    .ex_result    (ex_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_result    (wb_result),
    .operand      (op_a)
  );

  fwd_mux u_fwd_b (
    .src_addr     (in_rs2_addr),
    .reg_data     (in_rs2_data),
    .ex_reg_write (ex_reg_write),
    .ex_rd_addr   (ex_rd_addr),
    .ex_result    (ex_result),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_result    (wb_result),
    .operand      (op_b)
  );

`ifdef ID_EX_FORWARD_EN
  logic [REG_ADDR_W-1:0] hold_rs1;
  logic [REG_ADDR_W-1:0] hold_rs2;
  logic                  hold_imm;

  assign hazard_stall = 1'b0;

  // Source regs of the held instruction, so a WB write that lands
  // while we are stalled still reaches the held operand.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hold_rs1 <= '0;
      hold_rs2 <= '0;
      hold_imm <= 1'b0;
    end else if (!stall) begin
      hold_rs1 <= in_valid ? in_rs1_addr : '0;
      hold_rs2 <= in_valid ? in_rs2_addr : '0;
      hold_imm <= in_valid && in_use_imm;
    end
  end
`else
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rd_hit(ex_reg_write, ex_rd_addr, in_rs1_addr) ||
                   rd_hit(wb_reg_write, wb_rd_addr, in_rs1_addr);
  assign rs2_hit = rd_hit(ex_reg_write, ex_rd_addr, in_rs2_addr) ||
                   rd_hit(wb_reg_write, wb_rd_addr, in_rs2_addr);

  assign hazard_stall = in_valid && (rs1_hit || (!in_use_imm && rs2_hit));
`endif

  // Without forwarding the muxes still sit in the path: whenever they
  // would pick EX/WB data a hazard bubble is loaded instead, so only
  // in_rs*_data ever reaches the register.
  always_comb begin
    d = q;
    if (flush) begin
      d = '0;
    end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
      if (q.valid && rd_hit(wb_reg_write, wb_rd_addr, hold_rs1))
        d.alu_a = wb_result;
      if (q.valid && !hold_imm &&
          rd_hit(wb_reg_write, wb_rd_addr, hold_rs2))
        d.alu_b = wb_result;
`endif
    end else if (hazard_stall || !in_valid) begin
      d = '0;
    end else begin
      d.valid     = 1'b1;
      d.pc        = in_pc;
      d.alu_a     = op_a;
      d.alu_b     = in_use_imm ? in_imm : op_b;
      d.alu_ctrl  = in_alu_ctrl;
      d.rd_addr   = in_rd_addr;
      d.reg_write = in_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

  assign out_valid     = q.valid;
  assign out_pc        = q.pc;
  assign alu_a         = q.alu_a;
  assign alu_b         = q.alu_b;
  assign alu_ctrl      = q.alu_ctrl;
  assign out_rd_addr   = q.rd_addr;
  assign out_reg_write = q.reg_write && q.valid;

endmodule
